// File: rtl/chess_clock_ctrl_if.sv
// rtl/chess_clock_ctrl_if.sv - command/status bundle between move logic, datapath and the chess clock sequencer
interface chess_clock_ctrl_if;
    logic       start;
    logic       pause_toggle;
    logic       move_valid;
    logic       move_side;
    logic [9:0] time_white;
    logic [9:0] time_black;
    logic       load_clocks;
    logic       dec_white;
    logic       dec_black;
    logic       side_to_move;
    logic       running;
    logic       game_over;
    logic [1:0] winner;
    logic       move_accept;
    logic       move_reject;

    // master drives commands and time values, slave is the sequencer
    modport master (
        output start, pause_toggle, move_valid, move_side, time_white, time_black,
        input  load_clocks, dec_white, dec_black, side_to_move, running,
               game_over, winner, move_accept, move_reject
    );

    modport slave (
        input  start, pause_toggle, move_valid, move_side, time_white, time_black,
        output load_clocks, dec_white, dec_black, side_to_move, running,
               game_over, winner, move_accept, move_reject
    );
endinterface

// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-sided chess clock sequencer: 1 Hz tick, turn steering, pause, flag fall
module chess_clock_ctrl #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    chess_clock_ctrl_if.slave   bus
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_WHITE = 2'b01;
    localparam logic [1:0] WIN_BLACK = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          load_clocks;
    logic          dec_white;
    logic          dec_black;
    logic          side_to_move;
    logic          running;
    logic          game_over;
    logic [1:0]    winner;
    logic          move_accept;
    logic          move_reject;

    logic [9:0]    active_time;
    logic          flag_fall;
    logic          move_ok;

    // only the side whose clock is running can flag
    assign active_time = side_to_move ? bus.time_black : bus.time_white;
    assign flag_fall   = (active_time == 10'd0);
    assign move_ok     = bus.move_valid && (bus.move_side == side_to_move);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            load_clocks  <= 1'b0;
            dec_white    <= 1'b0;
            dec_black    <= 1'b0;
            side_to_move <= 1'b0;
            running      <= 1'b0;
            game_over    <= 1'b0;
            winner       <= WIN_NONE;
            move_accept  <= 1'b0;
            move_reject  <= 1'b0;
        end else begin
            load_clocks <= 1'b0;
            dec_white   <= 1'b0;
            dec_black   <= 1'b0;
            move_accept <= 1'b0;
            move_reject <= 1'b0;

            if (bus.start) begin
                state        <= RUN;
                presc        <= '0;
                load_clocks  <= 1'b1;
                side_to_move <= 1'b0;
                running      <= 1'b1;
                game_over    <= 1'b0;
                winner       <= WIN_NONE;
            end else begin
                unique case (state)
                    RUN: begin
                        if (flag_fall) begin
                            state       <= OVER;
                            running     <= 1'b0;
                            game_over   <= 1'b1;
                            winner      <= side_to_move ? WIN_WHITE : WIN_BLACK;
                            move_reject <= bus.move_valid;
                        end else begin
                            if (bus.pause_toggle) begin
                                state   <= PAUSED;
                                running <= 1'b0;
                            end
                            if (move_ok) begin
                                // restarting the second for the new side swallows any tick due now
                                move_accept  <= 1'b1;
                                side_to_move <= ~side_to_move;
                                presc        <= '0;
                            end else begin
                                move_reject <= bus.move_valid;
                                // the pausing cycle does not count, so a resume continues at the same point
                                if (!bus.pause_toggle) begin
                                    if (presc == PRESC_LAST) begin
                                        presc     <= '0;
                                        dec_white <= ~side_to_move;
                                        dec_black <= side_to_move;
                                    end else begin
                                        presc <= presc + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    PAUSED: begin
                        if (bus.pause_toggle) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                        move_reject <= bus.move_valid;
                    end
                    default: begin
                        move_reject <= bus.move_valid;
                    end
                endcase
            end
        end
    end

    assign bus.load_clocks  = load_clocks;
    assign bus.dec_white    = dec_white;
    assign bus.dec_black    = dec_black;
    assign bus.side_to_move = side_to_move;
    assign bus.running      = running;
    assign bus.game_over    = game_over;
    assign bus.winner       = winner;
    assign bus.move_accept  = move_accept;
    assign bus.move_reject  = move_reject;

endmodule

// File: doc/chess_clock_ctrl.md
Name: chess_clock_ctrl

Overview:
Sequencer for the two-sided chess countdown timer datapath. It generates the 1 Hz decrement enables from the fast system clock and steers them to the side to move. It accepts move-commit pulses from the move-input logic, toggles the turn, and handles start, pause and restart. It detects flag fall on the active side and latches the game result for the display and game-state logic.

Parameters:
TICK_CYCLES, 100000000, clk cycles per one-second tick; minimum 2; benches use 4.

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  1-cycle pulse; (re)starts a game from any state
pause_toggle  in  1  1-cycle pulse; RUN<->PAUSED
move_valid  in  1  1-cycle pulse; a legal move was entered
move_side  in  1  side that made the move; 0 white, 1 black (same encoding as moveData[13])
time_white  in  10  white remaining time {min[2:0], sec_tens[2:0], sec_ones[3:0]}
time_black  in  10  black remaining time, same format
load_clocks  out  1  1-cycle pulse; datapath reloads both sides to 4:59
dec_white  out  1  1-cycle pulse; datapath decrements white by 1 s
dec_black  out  1  1-cycle pulse; datapath decrements black by 1 s
side_to_move  out  1  0 white, 1 black
running  out  1  high only in RUN
game_over  out  1  high in OVER
winner  out  2  00 none, 01 white won, 10 black won; 11 never driven
move_accept  out  1  1-cycle pulse; move taken, turn switched
move_reject  out  1  1-cycle pulse; move ignored

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk. During reset: state IDLE, prescaler 0, side_to_move 0, every other output 0.
- States: IDLE, RUN, PAUSED, OVER. All outputs are registered.
- Start (any state): next cycle gives load_clocks=1 for one cycle, state RUN, side_to_move=0, prescaler=0, winner=00.
  - start has priority over pause_toggle and move_valid in the same cycle; the move is neither accepted nor rejected.
- pause_toggle: RUN->PAUSED, PAUSED->RUN. Ignored in IDLE and OVER.
  - The prescaler holds its value in PAUSED and resumes from it.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 only in RUN.
  - On the cycle it equals TICK_CYCLES-1 it wraps to 0 and a tick fires: next cycle, dec_white pulses if side_to_move=0, or dec_black if side_to_move=1.
  - No tick fires in any other state.
- Move handling:
  - Accepted only in RUN with move_side==side_to_move. Next cycle: move_accept=1, side_to_move inverted, prescaler cleared to 0.
  - A tick coinciding with an accepted move is suppressed; no dec pulse.
  - Otherwise (wrong side, or IDLE/PAUSED/OVER) move_valid gives move_reject=1 next cycle; no state change.
- Flag fall:
  - In RUN, if the active side's time input equals 10'd0, next cycle: state OVER, running=0, game_over=1, winner = opposite side (white flags -> 10, black flags -> 01).
  - Flag detection has priority over move_valid and tick in the same cycle; the move is rejected and no dec pulse is issued.
  - The inactive side at zero is not checked.
- OVER holds game_over, winner and side_to_move until start or rst.
- The datapath updates its time outputs one cycle after a dec pulse. The controller never issues dec pulses on consecutive cycles (TICK_CYCLES>=2).
- At most one of dec_white/dec_black is high in any cycle. load_clocks is never coincident with a dec pulse.
- rst asserted mid-game returns to IDLE immediately, regardless of clk.

Test Plan:
- Reset then start (TICK_CYCLES=4) -> load_clocks pulses once; running=1; dec_white pulses every 4 cycles; dec_black stays 0.
- In RUN (white to move), move_valid with move_side=0 -> move_accept; side_to_move=1; the next dec_black comes 4 cycles later; move_side=1 while white to move -> move_reject, no turn change.
- pause_toggle after 2 prescaler counts, hold 10 cycles, pause_toggle again -> no dec pulses while paused; first dec 2 cycles after resume.
- Drive time_white=10'd0 with white to move -> game_over=1, winner=10, running=0; a move_valid in that same cycle -> move_reject; no further dec pulses.
- move_valid (correct side) on the same cycle as the prescaler wrap -> move_accept, no dec pulse that cycle; start and pause_toggle together in OVER -> new game in RUN, winner=00.
- rst asserted mid-RUN between clk edges -> outputs clear immediately; after release the block is in IDLE and ignores move_valid (move_reject pulses).
